// File: rtl/clock_pkg.sv
// Shared types and constants for the alarm-clock front panel.
package clock_pkg;

  // Packed time word: hours, minutes, seconds (17 bits in total).
  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } time_t;

  localparam int TIME_W_DEF = $bits(time_t);

  // Mode indices with a fixed meaning; further modes follow these.
  localparam int MODE_CLOCK = 0;
  localparam int MODE_ALARM = 1;

  // Per-button hold-to-repeat state.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    LOCKED = 2'd3
  } rpt_state_e;

endpackage

// File: rtl/btn_repeat.sv
// Converts one debounced button level into a press pulse followed by
// auto-repeat pulses while the button stays down. A lock request (mode
// advance) while the button is down suppresses pulses until release.
module btn_repeat
  import clock_pkg::*;
#(
  parameter int HOLD_CYCLES   = 1024,
  parameter int REPEAT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic in_signal,
  input  logic lock,
  output logic pulse
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  rpt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prev_q, prev_d;
  logic             rise;
  logic             pulse_c;

  // The pulse is produced here combinationally; the top registers it
  // together with the routing so every output still comes from a flop.
  assign pulse = pulse_c;

  // Next-state, counter and pulse decision for the repeat generator.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_c = 1'b0;
    prev_d  = in_signal;
    rise    = in_signal & ~prev_q;
    if (!in_signal) begin
      // Release always wins, even over a counter that expires now.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (lock) begin
      // Mode changed under a held button: wait for a fresh press.
      state_d = LOCKED;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d = HOLD;
            cnt_d   = '0;
            pulse_c = 1'b1;
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = REPEAT;
            cnt_d   = '0;
            pulse_c = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        REPEAT: begin
          if (cnt_q == RPT_LAST) begin
            cnt_d   = '0;
            pulse_c = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        LOCKED: begin
          state_d = LOCKED;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State register; edge history resets high so a button held through
  // reset is not mistaken for a new press.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= prev_d;
    end
  end

endmodule

// File: rtl/multi_mode_router.sv
// Front-panel router: cycles the active mode, steers edit pulses to the
// active mode's consumer, selects its time for display and falls back to
// the clock mode after a period of inactivity.
module multi_mode_router
  import clock_pkg::*;
#(
  parameter int NUM_MODES      = 3,
  parameter int NUM_BTNS       = 2,
  parameter int TIME_W         = TIME_W_DEF,
  parameter int HOLD_CYCLES    = 1024,
  parameter int REPEAT_CYCLES  = 256,
  parameter int TIMEOUT_CYCLES = 2 ** 26,
  localparam int MODE_W        = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          mode_btn,
  input  logic [NUM_BTNS-1:0]           in_edit_btns,
  input  logic [NUM_MODES*TIME_W-1:0]   times_in,
  output logic [NUM_MODES*NUM_BTNS-1:0] edit_pulses,
  output logic [MODE_W-1:0]             mode,
  output logic [TIME_W-1:0]             display_time,
  output logic                          timeout_evt
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]   TMO_LAST   = TO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [MODE_W-1:0] MODE_LAST  = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_HOME  = MODE_W'(MODE_CLOCK);

  logic                          mode_prev_q, mode_prev_d;
  logic [MODE_W-1:0]             mode_q, mode_d;
  logic [TO_W-1:0]               tmo_cnt_q, tmo_cnt_d;
  logic                          tmo_evt_q, tmo_evt_d;
  logic [NUM_MODES*NUM_BTNS-1:0] edit_q, edit_d;
  logic [NUM_BTNS-1:0]           btn_pulse;
  logic                          mode_rise;
  logic                          tmo_hit;
  logic                          mode_adv;

  for (genvar b = 0; b < NUM_BTNS; b++) begin : g_btn
    btn_repeat #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_rpt (
      .clk      (clk),
      .reset    (reset),
      .in_signal(in_edit_btns[b]),
      .lock     (mode_adv),
      .pulse    (btn_pulse[b])
    );
  end

  // Mode stepping: a mode_btn edge advances, an expired inactivity count
  // returns home. The timeout test looks only at the counter so the lock
  // fed to the generators never depends on their own pulses; the counter
  // is cleared by every pulse, so a pulse and a timeout cannot coincide
  // unless HOLD_CYCLES exceeds the timeout.
  always_comb begin
    mode_prev_d = mode_btn;
    mode_rise   = mode_btn & ~mode_prev_q;
    tmo_hit     = ~mode_rise & (mode_q != MODE_HOME) & (tmo_cnt_q == TMO_LAST);
    mode_adv    = mode_rise | tmo_hit;
    tmo_evt_d   = tmo_hit;
    mode_d      = mode_q;
    if (tmo_hit) begin
      mode_d = MODE_HOME;
    end else if (mode_rise) begin
      mode_d = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
    end
  end

  // Inactivity counter and edit-pulse routing into the current mode slice.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 1'b1;
    if (mode_rise || (|btn_pulse) || (mode_q == MODE_HOME) || tmo_hit) begin
      tmo_cnt_d = '0;
    end
    edit_d = '0;
    edit_d[int'(mode_q)*NUM_BTNS +: NUM_BTNS] = btn_pulse;
  end

  // Registered control state and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_prev_q <= 1'b1;
      mode_q      <= MODE_HOME;
      tmo_cnt_q   <= '0;
      tmo_evt_q   <= 1'b0;
      edit_q      <= '0;
    end else begin
      mode_prev_q <= mode_prev_d;
      mode_q      <= mode_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tmo_evt_q   <= tmo_evt_d;
      edit_q      <= edit_d;
    end
  end

  assign mode         = mode_q;
  assign edit_pulses  = edit_q;
  assign timeout_evt  = tmo_evt_q;
  assign display_time = times_in[int'(mode_q)*TIME_W +: TIME_W];

endmodule

// File: doc/multi_mode_router.md
# multi_mode_router

Parametrised front-panel router for the alarm clock. It takes the debounced mode and edit buttons and converts each edit button into press and auto-repeat pulses. Those pulses are steered to exactly one of NUM_MODES time-keeping consumers (clock, alarm, timer, …), and that consumer's time is selected for the display. It sits between the debouncers and the time-keeping blocks. Beyond a fixed two-way selector, it adds a mode-cycle button, hold-to-repeat, re-press lockout after a mode change, and an inactivity timeout back to mode 0.

## Interface
Parameters:
- NUM_MODES, 3, number of modes; ≥2; mode 0 is the normal clock
- NUM_BTNS, 2, edit buttons per mode (msb = hours, lsb = minutes for the 2-button case)
- TIME_W, 17, width of one time word
- HOLD_CYCLES, 1024, hold time from press pulse to first repeat pulse; ≥2
- REPEAT_CYCLES, 256, period between repeat pulses; ≥2
- TIMEOUT_CYCLES, 2^26, inactivity cycles before returning to mode 0; ≥2

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mode_btn  in  1  debounced mode-cycle button level
- in_edit_btns  in  NUM_BTNS  debounced edit button levels
- times_in  in  NUM_MODES*TIME_W  time word of each mode; mode m occupies bits [m*TIME_W +: TIME_W]
- edit_pulses  out  NUM_MODES*NUM_BTNS  one-cycle edit strobes; slice m is [m*NUM_BTNS +: NUM_BTNS]
- mode  out  MODE_W  current mode index; MODE_W = max(1, $clog2(NUM_MODES))
- display_time  out  TIME_W  times_in slice selected by mode
- timeout_evt  out  1  one-cycle strobe on automatic return to mode 0

## Operation
- **Mode register**
  - Reset value 0.
  - A rising edge of mode_btn sets mode to (mode+1) mod NUM_MODES, wrapping NUM_MODES-1 → 0.
- **Repeat generator (one per edit button)**
  - States: IDLE, HOLD, REPEAT, LOCKED.
  - IDLE → HOLD on a rising edge of the input. This emits a press pulse and clears the counter.
  - HOLD → REPEAT when the counter reaches HOLD_CYCLES-1. This emits a pulse and clears the counter.
  - In REPEAT, a pulse is emitted each time the counter reaches REPEAT_CYCLES-1, then the counter clears.
  - Input low in any state → IDLE on the next edge, with no pulse.
  - LOCKED: entered from any state when the mode advances (button edge or timeout) while the input is high. Stays there with no pulses until the input goes low, then → IDLE.
  - A mode advance while the input is low has no effect on the generator.
- **Routing**
  - The pulse vector is ANDed into slice [mode] of edit_pulses; all other slices are 0.
  - The current registered mode is used, so on a cycle where mode changes, pulses go to the old mode.
  - Because of the LOCKED rule, no pulse follows into the new mode without a re-press.
- **Simultaneous mode_btn edge and edit edge on the same clock**
  - The mode advances.
  - The edit generator goes to LOCKED, not HOLD, and emits no pulse.
- **Display:** display_time = times_in slice [mode], combinational from the mode register.
- **Inactivity timeout**
  - The counter clears on any mode_btn edge, any nonzero edit pulse, or whenever mode == 0.
  - It increments otherwise.
  - On reaching TIMEOUT_CYCLES-1: mode ← 0, timeout_evt = 1 for one cycle, counter clears.
  - A held button in REPEAT keeps producing pulses, so it prevents timeout.
  - A held button in LOCKED does not prevent timeout.
- **Reset**
  - Values after reset: mode 0, all generators IDLE, counters 0, edit_pulses 0, timeout_evt 0.
  - display_time = times_in slice 0.
  - Edge-detect history registers reset to 1. A button already held at reset release produces no pulse and no mode step.

## Timing
- Rising edge first sampled at clock edge k → press pulse (or mode step) visible in the cycle after edge k. That is one cycle of latency, and the pulse lasts one cycle.
- First repeat pulse: HOLD_CYCLES cycles after the press pulse.
- Subsequent repeat pulses: every REPEAT_CYCLES cycles.
- Release at edge r: no pulse in the cycle after r, even if the counter would have expired on that edge.
- timeout_evt and the mode change to 0 are visible in the same cycle.
- All outputs are registered or derived combinationally from registered state plus times_in. There is no combinational path from button inputs to outputs.

## Structure
- Shared package clock_pkg holds:
  - time_t (TIME_W-bit packed hours/minutes/seconds)
  - the mode index constants MODE_CLOCK = 0 and MODE_ALARM = 1
  - the repeat-state enum (IDLE, HOLD, REPEAT, LOCKED)
- Sub-module btn_repeat with ports clk, reset, in_signal, lock, pulse and parameters HOLD_CYCLES, REPEAT_CYCLES. Instantiated NUM_BTNS times via generate.
- The mode register, timeout counter and routing live in the top module.

## Test plan
Bench parameters: NUM_MODES=3, NUM_BTNS=2, HOLD=8, REPEAT=4, TIMEOUT=32.
- Reset with mode_btn held, then release and press → no step on release; press gives mode 0→1 one cycle after the sampled edge; further presses give 1→2→0; display_time tracks slices 1, 2, 0.
- Mode 1, hold in_edit_btns=2'b10 for 20 cycles → edit_pulses bit 3 pulses at relative cycles 1, 9, 13, 17; all other bits stay 0.
- Mode 0, hold bit 0 through a mode_btn press → pulses only in slice 0; after the mode step no pulses until release and re-press, then bit 2 pulses.
- mode_btn and edit bit 0 rising on the same edge in mode 1 → mode becomes 2; edit_pulses stays 0.
- Mode 2, idle 31 cycles → mode 0, timeout_evt for 1 cycle. Repeat with an edit press at idle cycle 20 → no timeout until 31 cycles after that pulse.
- Assert reset mid-REPEAT in mode 2 → next cycle: mode 0, edit_pulses 0, timeout_evt 0; button still held gives no pulse.
